// File: rtl/aap_fetch_pkg.sv
// rtl/aap_fetch_pkg.sv - shared widths and instruction-length helper for the AAP fetch queue
package aap_fetch_pkg;

    localparam int IWORD_W  = 16;
    localparam int INSTR_W  = 32;
    localparam int IS32_BIT = 15;

    // Length of an instruction in 16-bit words, decided by its first word only
    function automatic logic [1:0] instr_words(input logic [IWORD_W-1:0] first);
        return first[IS32_BIT] ? 2'd2 : 2'd1;
    endfunction

endpackage

// File: rtl/aap_fetch_word_fifo.sv
// rtl/aap_fetch_word_fifo.sv - word FIFO tagged with fetch address, 0/1/2-word pop, head and head+1 reads
module aap_fetch_word_fifo
    import aap_fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = 36,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clear,
    input  logic          i_push,
    input  logic [DW-1:0] i_push_data,
    input  logic [1:0]    i_pop_n,
    output logic [CW-1:0] o_count,
    output logic [DW-1:0] o_head,
    output logic [DW-1:0] o_head1
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic [PW-1:0] w_head1;

    assign w_head1 = r_head + PW'(1);
    assign o_count = r_count;
    assign o_head  = r_mem[r_head];
    assign o_head1 = r_mem[w_head1];

    // The producer only pushes with free space, so count never exceeds DEPTH
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_clear) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_tail] <= i_push_data;
                r_tail        <= r_tail + PW'(1);
            end
            r_head  <= r_head + PW'(i_pop_n);
            r_count <= r_count + CW'(i_push) - CW'(i_pop_n);
        end
    end

endmodule

// File: rtl/aap_fetch_queue.sv
// rtl/aap_fetch_queue.sv - prefetch queue assembling 16/32-bit AAP instructions with redirect support
module aap_fetch_queue
    import aap_fetch_pkg::*;
#(
    parameter int                 IADDR_W  = 20,
    parameter int                 DEPTH    = 4,
    parameter logic [IADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               flush,
    input  logic [IADDR_W-1:0] flush_pc,
    output logic [IADDR_W-1:0] imem_addr,
    output logic               imem_req,
    input  logic [IWORD_W-1:0] imem_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic               out_is32,
    output logic [IADDR_W-1:0] out_pc
);

    localparam int DW = IWORD_W + IADDR_W;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [IADDR_W-1:0] r_fetch_pc;
    logic [IADDR_W-1:0] r_resp_pc;
    logic               r_inflight;
    logic               r_discard;

    logic [CW-1:0]      w_count;
    logic [DW-1:0]      w_head;
    logic [DW-1:0]      w_head1;
    logic [IWORD_W-1:0] w_head_word;
    logic [IWORD_W-1:0] w_head1_word;
    logic [IADDR_W-1:0] w_head_pc;
    logic               w_head_is32;
    logic               w_valid;
    logic               w_issue;
    logic               w_push;
    logic [1:0]         w_pop_n;

    assign w_head_word  = w_head[IWORD_W-1:0];
    assign w_head1_word = w_head1[IWORD_W-1:0];
    assign w_head_pc    = w_head[DW-1:IWORD_W];
    assign w_head_is32  = w_head_word[IS32_BIT];

    // Space is judged before this cycle's pop so issue never depends on out_ready
    assign w_issue = !flush && ((w_count + CW'(r_inflight)) < CW'(DEPTH));
    assign w_push  = r_inflight && !r_discard;

    assign w_valid = (w_count >= CW'(1) && !w_head_is32) ||
                     (w_count >= CW'(2) &&  w_head_is32);

    assign w_pop_n = (w_valid && out_ready && !flush) ? instr_words(w_head_word) : 2'd0;

    assign imem_req  = w_issue && !reset;
    assign imem_addr = reset ? '0 : r_fetch_pc;

    always_comb begin
        out_valid = 1'b0;
        out_instr = '0;
        out_is32  = 1'b0;
        out_pc    = '0;
        if (w_valid) begin
            out_valid = 1'b1;
            out_is32  = w_head_is32;
            out_pc    = w_head_pc;
            out_instr = w_head_is32 ? {w_head_word, w_head1_word}
                                    : {{(INSTR_W-IWORD_W){1'b0}}, w_head_word};
        end
    end

    aap_fetch_word_fifo #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_fifo (
        .i_clk       (clock),
        .i_rst       (reset),
        .i_clear     (flush),
        .i_push      (w_push),
        .i_push_data ({r_resp_pc, imem_data}),
        .i_pop_n     (w_pop_n),
        .o_count     (w_count),
        .o_head      (w_head),
        .o_head1     (w_head1)
    );

    // A response landing in the flush cycle is dropped by the FIFO clear;
    // discard covers any response still owed after the redirect
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC;
            r_resp_pc  <= '0;
            r_inflight <= 1'b0;
            r_discard  <= 1'b0;
        end else if (flush) begin
            r_fetch_pc <= flush_pc;
            r_inflight <= 1'b0;
            r_discard  <= r_inflight;
        end else begin
            r_inflight <= w_issue;
            r_discard  <= 1'b0;
            if (w_issue) begin
                r_fetch_pc <= r_fetch_pc + IADDR_W'(1);
                r_resp_pc  <= r_fetch_pc;
            end
        end
    end

endmodule

// File: tb/tb_aap_fetch_queue.sv
// tb/tb_aap_fetch_queue.sv - scoreboard bench for aap_fetch_queue
module tb_aap_fetch_queue;

    typedef struct packed {
        logic [31:0] instr;
        logic        is32;
        logic [19:0] pc;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset, flush, out_ready;
    logic [19:0] flush_pc;
    logic [19:0] imem_addr;
    logic        imem_req;
    logic [15:0] imem_data = '0;
    logic        out_valid, out_is32;
    logic [31:0] out_instr;
    logic [19:0] out_pc;

    logic        rst_w, ready_w;
    logic [19:0] imem_addr_w;
    logic        imem_req_w;
    logic [15:0] imem_data_w = '0;
    logic        out_valid_w, out_is32_w;
    logic [31:0] out_instr_w;
    logic [19:0] out_pc_w;

    logic [15:0] mem [int];
    exp_t        sb [$];
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clock = ~clock;

    aap_fetch_queue #(.IADDR_W(20), .DEPTH(4), .RESET_PC(20'h00000)) dut (
        .clock(clock), .reset(reset), .flush(flush), .flush_pc(flush_pc),
        .imem_addr(imem_addr), .imem_req(imem_req), .imem_data(imem_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_is32(out_is32), .out_pc(out_pc)
    );

    aap_fetch_queue #(.IADDR_W(20), .DEPTH(4), .RESET_PC(20'hFFFFF)) dut_w (
        .clock(clock), .reset(rst_w), .flush(1'b0), .flush_pc(20'h0),
        .imem_addr(imem_addr_w), .imem_req(imem_req_w), .imem_data(imem_data_w),
        .out_valid(out_valid_w), .out_ready(ready_w), .out_instr(out_instr_w),
        .out_is32(out_is32_w), .out_pc(out_pc_w)
    );

    function automatic logic [15:0] memrd(input logic [19:0] a);
        if (mem.exists(int'(a))) return mem[int'(a)];
        return {1'b0, a[14:0]};
    endfunction

    // One-cycle instruction memory; garbage when no read is issued
    always @(posedge clock) begin
        imem_data   <= imem_req   ? memrd(imem_addr)   : 16'($urandom);
        imem_data_w <= imem_req_w ? memrd(imem_addr_w) : 16'($urandom);
    end

    task automatic build_sb(input logic [19:0] start, input int n);
        logic [19:0] pc;
        logic [15:0] w;
        pc = start;
        for (int i = 0; i < n; i++) begin
            w = memrd(pc);
            if (w[15]) begin
                sb.push_back(exp_t'({w, memrd(pc + 20'd1), 1'b1, pc}));
                pc = pc + 20'd2;
            end else begin
                sb.push_back(exp_t'({16'h0000, w, 1'b0, pc}));
                pc = pc + 20'd1;
            end
        end
    endtask

    task automatic start(input logic rdy);
        reset = 1'b1;
        flush = 1'b0;
        out_ready = rdy;
        sb.delete();
        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; flush = 1'b0; out_ready = 1'b1; flush_pc = '0;
        rst_w = 1'b1; ready_w = 1'b0;
        repeat (3) @(negedge clock);
        vectors++;
        if ({out_valid, imem_req, imem_addr, out_instr, out_is32, out_pc} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs got valid=%b req=%b addr=%h instr=%h is32=%b pc=%h want all 0",
                     out_valid, imem_req, imem_addr, out_instr, out_is32, out_pc);
        end
    endtask

    task automatic test_stream16;
        exp_t e;
        mem.delete();
        mem[0] = 16'h0001; mem[1] = 16'h0002; mem[2] = 16'h0003; mem[3] = 16'h0004;
        start(1'b1);
        build_sb(20'h0, 10);
        vectors++;
        if (imem_req !== 1'b1 || imem_addr !== 20'h0) begin
            miscompares++;
            $display("FAIL t1_first_issue got req=%b addr=%h want 1/00000", imem_req, imem_addr);
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            vectors++;
            if (k == 0) begin
                if (out_valid !== 1'b0 || out_instr !== 32'h0) begin
                    miscompares++;
                    $display("FAIL t1_latency got valid=%b instr=%h want 0/0", out_valid, out_instr);
                end
            end else if (out_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL t1_stream_valid cycle %0d got %b want 1", k, out_valid);
            end else begin
                e = sb.pop_front();
                if ({out_instr, out_is32, out_pc} !== e) begin
                    miscompares++;
                    $display("FAIL t1_instr got %h/%b/%h want %h/%b/%h",
                             out_instr, out_is32, out_pc, e.instr, e.is32, e.pc);
                end
            end
        end
    endtask

    task automatic test_mixed32;
        exp_t e;
        int   pops;
        mem.delete();
        mem[0] = 16'h8123; mem[1] = 16'h8456; mem[2] = 16'h0007;
        start(1'b1);
        build_sb(20'h0, 12);
        pops = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            if (out_valid) begin
                e = sb.pop_front();
                pops++;
                vectors++;
                if ({out_instr, out_is32, out_pc} !== e) begin
                    miscompares++;
                    $display("FAIL t2_instr got %h/%b/%h want %h/%b/%h",
                             out_instr, out_is32, out_pc, e.instr, e.is32, e.pc);
                end
            end
        end
        vectors++;
        if (pops < 6) begin
            miscompares++;
            $display("FAIL t2_pop_count got %0d want >=6", pops);
        end
    endtask

    task automatic test_backpressure;
        exp_t        e;
        int          reqs, pops;
        logic [19:0] last;
        mem.delete();
        start(1'b0);
        build_sb(20'h0, 16);
        reqs = 0; last = '0;
        if (imem_req) begin reqs++; last = imem_addr; end
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            if (imem_req) begin reqs++; last = imem_addr; end
        end
        vectors++;
        if (reqs !== 4 || last !== 20'h3) begin
            miscompares++;
            $display("FAIL t3_issue_stop got reqs=%0d last=%h want 4/00003", reqs, last);
        end
        vectors++;
        if (out_valid !== 1'b1 || out_pc !== 20'h0) begin
            miscompares++;
            $display("FAIL t3_head_held got valid=%b pc=%h want 1/00000", out_valid, out_pc);
        end
        out_ready = 1'b1;
        pops = 0;
        for (int k = 0; k < 10; k++) begin
            if (out_valid) begin
                e = sb.pop_front();
                pops++;
                vectors++;
                if ({out_instr, out_is32, out_pc} !== e) begin
                    miscompares++;
                    $display("FAIL t3_order got %h/%b/%h want %h/%b/%h",
                             out_instr, out_is32, out_pc, e.instr, e.is32, e.pc);
                end
            end
            @(negedge clock);
        end
        vectors++;
        if (pops < 8) begin
            miscompares++;
            $display("FAIL t3_drain_count got %0d want >=8", pops);
        end
    endtask

    task automatic test_flush;
        exp_t e;
        mem.delete();
        start(1'b1);
        build_sb(20'h0, 20);
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            if (out_valid) begin
                e = sb.pop_front();
                vectors++;
                if ({out_instr, out_is32, out_pc} !== e) begin
                    miscompares++;
                    $display("FAIL t4_pre_flush got %h/%b/%h want %h/%b/%h",
                             out_instr, out_is32, out_pc, e.instr, e.is32, e.pc);
                end
            end
        end
        flush = 1'b1;
        flush_pc = 20'h00100;
        #1;
        vectors++;
        if (imem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL t4_no_issue_in_flush got req=%b want 0", imem_req);
        end
        sb.delete();
        build_sb(20'h00100, 8);
        @(negedge clock);
        flush = 1'b0;
        #1;
        vectors++;
        if (imem_req !== 1'b1 || imem_addr !== 20'h00100 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL t4_redirect_issue got req=%b addr=%h valid=%b want 1/00100/0",
                     imem_req, imem_addr, out_valid);
        end
        @(negedge clock);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL t4_bubble got valid=%b want 0", out_valid);
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            vectors++;
            if (out_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL t4_post_valid cycle %0d got %b want 1", k, out_valid);
            end else begin
                e = sb.pop_front();
                if ({out_instr, out_is32, out_pc} !== e) begin
                    miscompares++;
                    $display("FAIL t4_post_instr got %h/%b/%h want %h/%b/%h",
                             out_instr, out_is32, out_pc, e.instr, e.is32, e.pc);
                end
            end
        end
    endtask

    task automatic test_wrap;
        bit seen;
        mem.delete();
        mem[20'hFFFFF] = 16'h8AAA;
        mem[0] = 16'h8BBB;
        ready_w = 1'b1;
        @(negedge clock);
        rst_w = 1'b0;
        #1;
        vectors++;
        if (imem_req_w !== 1'b1 || imem_addr_w !== 20'hFFFFF) begin
            miscompares++;
            $display("FAIL t5_first_addr got req=%b addr=%h want 1/fffff", imem_req_w, imem_addr_w);
        end
        @(negedge clock);
        vectors++;
        if (imem_addr_w !== 20'h0) begin
            miscompares++;
            $display("FAIL t5_addr_wrap got %h want 00000", imem_addr_w);
        end
        seen = 1'b0;
        for (int k = 0; k < 6 && !seen; k++) begin
            @(negedge clock);
            if (out_valid_w) seen = 1'b1;
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL t5_timeout got no valid want valid within 6 cycles");
        end else if ({out_instr_w, out_is32_w, out_pc_w} !== {32'h8AAA8BBB, 1'b1, 20'hFFFFF}) begin
            miscompares++;
            $display("FAIL t5_span got %h/%b/%h want 8aaa8bbb/1/fffff", out_instr_w, out_is32_w, out_pc_w);
        end
        @(negedge clock);
        vectors++;
        if ({out_valid_w, out_instr_w, out_pc_w} !== {1'b1, 32'h00000001, 20'h00001}) begin
            miscompares++;
            $display("FAIL t5_after_wrap got %b/%h/%h want 1/00000001/00001", out_valid_w, out_instr_w, out_pc_w);
        end
        rst_w = 1'b1;
    endtask

    task automatic test_async_reset;
        exp_t e;
        int   pops;
        mem.delete();
        start(1'b0);
        repeat (4) @(negedge clock);
        vectors++;
        if (out_valid !== 1'b1 || out_pc !== 20'h0) begin
            miscompares++;
            $display("FAIL t6_prefill got valid=%b pc=%h want 1/00000", out_valid, out_pc);
        end
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if ({out_valid, imem_req, imem_addr, out_instr, out_is32, out_pc} !== '0) begin
            miscompares++;
            $display("FAIL t6_async_drop got valid=%b req=%b addr=%h instr=%h pc=%h want all 0",
                     out_valid, imem_req, imem_addr, out_instr, out_pc);
        end
        @(negedge clock);
        reset = 1'b0;
        out_ready = 1'b1;
        build_sb(20'h0, 8);
        #1;
        vectors++;
        if (imem_req !== 1'b1 || imem_addr !== 20'h0) begin
            miscompares++;
            $display("FAIL t6_restart got req=%b addr=%h want 1/00000", imem_req, imem_addr);
        end
        pops = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            if (out_valid) begin
                e = sb.pop_front();
                pops++;
                vectors++;
                if ({out_instr, out_is32, out_pc} !== e) begin
                    miscompares++;
                    $display("FAIL t6_instr got %h/%b/%h want %h/%b/%h",
                             out_instr, out_is32, out_pc, e.instr, e.is32, e.pc);
                end
            end
        end
        vectors++;
        if (pops !== 5) begin
            miscompares++;
            $display("FAIL t6_pop_count got %0d want 5", pops);
        end
    endtask

    initial begin
        test_reset();
        test_stream16();
        test_mixed32();
        test_backpressure();
        test_flush();
        test_wrap();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/aap_fetch_queue.md
Name: aap_fetch_queue

Overview:
Parametrised successor to the single-word fetch stage. Streams 16-bit words from instruction memory into a DEPTH-entry prefetch queue. Assembles complete 16- or 32-bit AAP instructions for the decoder, using a valid/ready handshake. Supports redirect (flush) from execute for branches and jumps.

Parameters:
IADDR_W, 20, instruction word-address width (matches instruction memory read address)
DEPTH, 4, queue entries in 16-bit words; power of two, >= 2
RESET_PC, 0, word address fetched first after reset

Ports:
clock  in  1  system clock, all state updates on rising edge
reset  in  1  asynchronous, active-high; clears all state immediately
flush  in  1  redirect request from execute
flush_pc  in  IADDR_W  redirect target word address
imem_addr  out  IADDR_W  instruction memory read address
imem_req  out  1  read issued this cycle
imem_data  in  16  read data, valid exactly 1 cycle after imem_req
out_valid  out  1  complete instruction at queue head
out_ready  in  1  decoder accepts instruction
out_instr  out  32  {first,second} word if 32-bit; {16'h0,first} if 16-bit
out_is32  out  1  head instruction is 32-bit
out_pc  out  IADDR_W  word address of the head instruction's first word

Behaviour:
- Reset (async): fetch_pc=RESET_PC, count=0, inflight=0, discard=0. All outputs are 0 while reset is high.
- Issue: imem_req=1 when !flush && (count+inflight)<DEPTH. imem_addr=fetch_pc. On issue, fetch_pc increments and wraps modulo 2^IADDR_W. inflight is 0 or 1 (latency is 1 cycle). No credit is taken for a same-cycle pop.
- Response: the cycle after an issue, imem_data is pushed at the tail together with its address, unless discard=1. If discard=1 the word is dropped and discard clears.
- Instruction length: taken from head word bit 15. 0 means a 16-bit instruction; 1 means 32-bit. The second word's bit 15 is not checked.
- out_valid = (count>=1 && !head[15]) || (count>=2 && head[15]). Outputs are combinational from the queue head and are 0 when out_valid=0.
- Pop: on out_valid && out_ready, remove 1 word (16-bit) or 2 words (32-bit).
- Push and pop in the same cycle: count_next = count + push - pop_n. A full queue accepts a push in the same cycle it pops.
- Flush (priority over everything): count=0 next cycle and fetch_pc=flush_pc. If inflight=1, discard=1 so the stale response is dropped. No issue happens during the flush cycle. The first issue of flush_pc is the next cycle, and out_valid stays 0 for at least 2 cycles after flush. A pop presented in the flush cycle is ignored.
- Throughput: a steady stream of 16-bit instructions gives 1 per cycle after a 3-cycle startup. 32-bit instructions average 1 per 2 cycles.
- Wrap: fetch_pc 2^IADDR_W-1 is followed by 0. A 32-bit instruction spanning the wrap is assembled normally.
- Reset asserted mid-stream: queue contents and in-flight response are abandoned. After release, fetch restarts at RESET_PC.
- Pointers: head and tail indices are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.

Decomposition:
- Package aap_fetch_pkg: IWORD_W=16, INSTR_W=32, IS32_BIT=15, and a function for instruction length in words.
- Sub-module aap_fetch_word_fifo: DEPTH x (16+IADDR_W) storage with async reset. It has push, pop_n in {0,1,2}, clear, count, and head/head+1 read ports.
- Top level holds fetch_pc, inflight, discard and the handshake logic.

Test Plan:
1. Reset, memory words 0..3 = 16'h0001, 16'h0002, 16'h0003, 16'h0004, out_ready=1 -> first out_valid in cycle 3. Instructions 0x0001..0x0004 arrive on consecutive cycles with out_pc 0..3 and out_is32=0.
2. Words 0,1 = 16'h8123, 16'h8456, word 2 = 16'h0007 -> out_instr 32'h81238456 with is32=1 at pc 0, then 32'h00000007 at pc 2.
3. out_ready=0 for 10 cycles -> imem_req stops once count reaches 4. Queue holds pc 0..3. Release -> order preserved with no loss or duplicates.
4. Flush with flush_pc=20'h00100 while a request is inflight -> stale word not delivered. Next out_pc=20'h00100 with no valid before the 2-cycle bubble ends.
5. RESET_PC=20'hFFFFF, words FFFFF=16'h8AAA, 00000=16'h8BBB -> out_instr 32'h8AAA8BBB, out_pc 20'hFFFFF. imem_addr wraps to 0.
6. Assert reset asynchronously mid-cycle with count=3 -> out_valid and imem_req drop immediately. After release, fetch restarts at RESET_PC.
